// File: rtl/logic_axi4_stream_packet_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
// Covers the FSM state encoding, keep-mask and beat-count arithmetic, and keep popcount.
package logic_axi4_stream_packet_gen_pkg;

  localparam int unsigned MAX_BYTES = 64;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Low rem_bytes lanes set, or every lane once a full beat (or more) remains.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned rem_bytes,
                                                     input int unsigned data_bytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned j = 0; j < MAX_BYTES; j++) begin
      if ((j < data_bytes) && ((rem_bytes >= data_bytes) || (j < rem_bytes))) begin
        m[j] = 1'b1;
      end else begin
        m[j] = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic int unsigned beat_count(input int unsigned length,
                                             input int unsigned data_bytes);
    return (length + data_bytes - 32'd1) / data_bytes;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_BYTES-1:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int j = 0; j < MAX_BYTES; j++) begin
      cnt = cnt + 32'(v[j]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle used by the flat-port wrapper of the packet generator.
interface logic_axi4_stream_if #(
  parameter int unsigned TDATA_BYTES = 4,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TID_WIDTH-1:0]     tid;

  modport src (output tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid, input tready);
  modport snk (input tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid, output tready);
endinterface

// File: rtl/logic_axi4_stream_packet_gen_beat.sv
// Combinational beat formatter: (seed, beat index, bytes remaining) -> tdata/tkeep/tlast.
module logic_axi4_stream_packet_gen_beat
  import logic_axi4_stream_packet_gen_pkg::*;
#(
  parameter int unsigned TDATA_BYTES  = 4,
  parameter int unsigned LENGTH_WIDTH = 16
) (
  input  logic [7:0]               seed,
  input  logic [LENGTH_WIDTH-1:0]  beat_idx,
  input  logic [LENGTH_WIDTH-1:0]  remaining,
  output logic [TDATA_BYTES*8-1:0] tdata,
  output logic [TDATA_BYTES-1:0]   tkeep,
  output logic                     tlast
);

  logic [7:0] base_s;

  // Byte lanes carry seed + absolute byte offset, zeroed where keep is clear.
  always_comb begin
    base_s = 8'(32'(beat_idx) * TDATA_BYTES);
    tkeep  = TDATA_BYTES'(keep_mask(32'(remaining), TDATA_BYTES));
    tlast  = (beat_count(32'(remaining), TDATA_BYTES) == 32'd1);
    tdata  = '0;
    for (int j = 0; j < int'(TDATA_BYTES); j++) begin
      if (tkeep[j]) begin
        tdata[j*8 +: 8] = seed + base_s + 8'(j);
      end else begin
        tdata[j*8 +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/logic_axi4_stream_packet_gen_top.sv
// Flat-port wrapper routing the generator's stream through logic_axi4_stream_if.
// Optional statistics ports follow LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN.
module logic_axi4_stream_packet_gen_top #(
  parameter int unsigned TDATA_BYTES  = 4,
  parameter int unsigned TDEST_WIDTH  = 1,
  parameter int unsigned TUSER_WIDTH  = 1,
  parameter int unsigned TID_WIDTH    = 1,
  parameter int unsigned LENGTH_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LENGTH_WIDTH-1:0]  cmd_length,
  input  logic [7:0]               cmd_seed,
  input  logic [TDEST_WIDTH-1:0]   cmd_tdest,
  input  logic [TID_WIDTH-1:0]     cmd_tid,
  output logic                     tx_tvalid,
  output logic                     tx_tlast,
  output logic [TDATA_BYTES*8-1:0] tx_tdata,
  output logic [TDATA_BYTES-1:0]   tx_tkeep,
  output logic [TDATA_BYTES-1:0]   tx_tstrb,
  output logic [TDEST_WIDTH-1:0]   tx_tdest,
  output logic [TUSER_WIDTH-1:0]   tx_tuser,
  output logic [TID_WIDTH-1:0]     tx_tid,
  input  logic                     tx_tready,
  output logic                     busy
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
  ,
  output logic [31:0]              stat_packets,
  output logic [31:0]              stat_bytes
`endif
);

  logic_axi4_stream_if #(
    .TDATA_BYTES (TDATA_BYTES),
    .TDEST_WIDTH (TDEST_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH),
    .TID_WIDTH   (TID_WIDTH)
  ) tx_if ();

  logic_axi4_stream_packet_gen #(
    .TDATA_BYTES  (TDATA_BYTES),
    .TDEST_WIDTH  (TDEST_WIDTH),
    .TUSER_WIDTH  (TUSER_WIDTH),
    .TID_WIDTH    (TID_WIDTH),
    .LENGTH_WIDTH (LENGTH_WIDTH)
  ) u_gen (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_length (cmd_length),
    .cmd_seed   (cmd_seed),
    .cmd_tdest  (cmd_tdest),
    .cmd_tid    (cmd_tid),
    .tx_tvalid  (tx_if.tvalid),
    .tx_tlast   (tx_if.tlast),
    .tx_tdata   (tx_if.tdata),
    .tx_tkeep   (tx_if.tkeep),
    .tx_tstrb   (tx_if.tstrb),
    .tx_tdest   (tx_if.tdest),
    .tx_tuser   (tx_if.tuser),
    .tx_tid     (tx_if.tid),
    .tx_tready  (tx_if.tready),
    .busy       (busy)
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
    ,
    .stat_packets (stat_packets),
    .stat_bytes   (stat_bytes)
`endif
  );

  assign tx_tvalid    = tx_if.tvalid;
  assign tx_tlast     = tx_if.tlast;
  assign tx_tdata     = tx_if.tdata;
  assign tx_tkeep     = tx_if.tkeep;
  assign tx_tstrb     = tx_if.tstrb;
  assign tx_tdest     = tx_if.tdest;
  assign tx_tuser     = tx_if.tuser;
  assign tx_tid       = tx_if.tid;
  assign tx_if.tready = tx_tready;

endmodule

// File: rtl/logic_axi4_stream_packet_gen.sv
// AXI4-Stream packet generator core: one command in, one incrementing-byte packet out.
// Optional statistics counters enabled by LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN.
module logic_axi4_stream_packet_gen
  import logic_axi4_stream_packet_gen_pkg::*;
#(
  parameter int unsigned TDATA_BYTES  = 4,
  parameter int unsigned TDEST_WIDTH  = 1,
  parameter int unsigned TUSER_WIDTH  = 1,
  parameter int unsigned TID_WIDTH    = 1,
  parameter int unsigned LENGTH_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LENGTH_WIDTH-1:0]  cmd_length,
  input  logic [7:0]               cmd_seed,
  input  logic [TDEST_WIDTH-1:0]   cmd_tdest,
  input  logic [TID_WIDTH-1:0]     cmd_tid,
  output logic                     tx_tvalid,
  output logic                     tx_tlast,
  output logic [TDATA_BYTES*8-1:0] tx_tdata,
  output logic [TDATA_BYTES-1:0]   tx_tkeep,
  output logic [TDATA_BYTES-1:0]   tx_tstrb,
  output logic [TDEST_WIDTH-1:0]   tx_tdest,
  output logic [TUSER_WIDTH-1:0]   tx_tuser,
  output logic [TID_WIDTH-1:0]     tx_tid,
  input  logic                     tx_tready,
  output logic                     busy
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
  ,
  output logic [31:0]              stat_packets,
  output logic [31:0]              stat_bytes
`endif
);

  state_e                    state_r, state_s;
  logic [7:0]                seed_r, seed_s;
  logic [LENGTH_WIDTH-1:0]   beat_idx_r, beat_idx_s;
  logic [LENGTH_WIDTH-1:0]   rem_r, rem_s;

  logic                      tvalid_s, tlast_s;
  logic [TDATA_BYTES*8-1:0]  tdata_s;
  logic [TDATA_BYTES-1:0]    tkeep_s;
  logic [TDEST_WIDTH-1:0]    tdest_s;
  logic [TUSER_WIDTH-1:0]    tuser_s;
  logic [TID_WIDTH-1:0]      tid_s;

  logic                      hs_s, load_s, take_s, clear_s;
  logic [7:0]                fmt_seed_s;
  logic [LENGTH_WIDTH-1:0]   fmt_idx_s, fmt_rem_s;
  logic [TDATA_BYTES*8-1:0]  fmt_tdata_s;
  logic [TDATA_BYTES-1:0]    fmt_tkeep_s;
  logic                      fmt_tlast_s;

  // cmd_ready is held low while reset is asserted, then follows state and last handshake.
  assign cmd_ready = areset_n & ((state_r == ST_IDLE) | (tx_tvalid & tx_tready & tx_tlast));
  assign busy      = (state_r == ST_SEND);
  assign hs_s      = tx_tvalid & tx_tready;
  assign load_s    = cmd_valid & cmd_ready & (cmd_length != '0);

  // Formatter sees a fresh command when one loads, otherwise the beat after the current one.
  always_comb begin
    if (load_s) begin
      fmt_seed_s = cmd_seed;
      fmt_idx_s  = '0;
      fmt_rem_s  = cmd_length;
    end else begin
      fmt_seed_s = seed_r;
      fmt_idx_s  = beat_idx_r + LENGTH_WIDTH'(1);
      fmt_rem_s  = rem_r - LENGTH_WIDTH'(TDATA_BYTES);
    end
  end

  logic_axi4_stream_packet_gen_beat #(
    .TDATA_BYTES  (TDATA_BYTES),
    .LENGTH_WIDTH (LENGTH_WIDTH)
  ) u_beat (
    .seed      (fmt_seed_s),
    .beat_idx  (fmt_idx_s),
    .remaining (fmt_rem_s),
    .tdata     (fmt_tdata_s),
    .tkeep     (fmt_tkeep_s),
    .tlast     (fmt_tlast_s)
  );

  // Next-state and next-output logic; outputs hold unless a beat is taken or the packet ends.
  always_comb begin
    state_s    = state_r;
    take_s     = 1'b0;
    clear_s    = 1'b0;
    seed_s     = seed_r;
    beat_idx_s = beat_idx_r;
    rem_s      = rem_r;
    tvalid_s   = tx_tvalid;
    tlast_s    = tx_tlast;
    tdata_s    = tx_tdata;
    tkeep_s    = tx_tkeep;
    tdest_s    = tx_tdest;
    tuser_s    = tx_tuser;
    tid_s      = tx_tid;

    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          state_s = ST_SEND;
          take_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hs_s) begin
          if (tx_tlast) begin
            if (load_s) begin
              state_s = ST_SEND;
              take_s  = 1'b1;
            end else begin
              state_s = ST_IDLE;
              clear_s = 1'b1;
            end
          end else begin
            state_s = ST_SEND;
            take_s  = 1'b1;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase

    if (take_s) begin
      seed_s     = fmt_seed_s;
      beat_idx_s = fmt_idx_s;
      rem_s      = fmt_rem_s;
      tvalid_s   = 1'b1;
      tlast_s    = fmt_tlast_s;
      tdata_s    = fmt_tdata_s;
      tkeep_s    = fmt_tkeep_s;
      tuser_s    = '0;
      tuser_s[0] = load_s;
      if (load_s) begin
        tdest_s = cmd_tdest;
        tid_s   = cmd_tid;
      end else begin
        tdest_s = tx_tdest;
        tid_s   = tx_tid;
      end
    end else if (clear_s) begin
      seed_s     = 8'h00;
      beat_idx_s = '0;
      rem_s      = '0;
      tvalid_s   = 1'b0;
      tlast_s    = 1'b0;
      tdata_s    = '0;
      tkeep_s    = '0;
      tdest_s    = '0;
      tuser_s    = '0;
      tid_s      = '0;
    end else begin
      tvalid_s   = tx_tvalid;
    end
  end

  // State, counters and all registered stream outputs.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r    <= ST_IDLE;
      seed_r     <= 8'h00;
      beat_idx_r <= '0;
      rem_r      <= '0;
      tx_tvalid  <= 1'b0;
      tx_tlast   <= 1'b0;
      tx_tdata   <= '0;
      tx_tkeep   <= '0;
      tx_tstrb   <= '0;
      tx_tdest   <= '0;
      tx_tuser   <= '0;
      tx_tid     <= '0;
    end else begin
      state_r    <= state_s;
      seed_r     <= seed_s;
      beat_idx_r <= beat_idx_s;
      rem_r      <= rem_s;
      tx_tvalid  <= tvalid_s;
      tx_tlast   <= tlast_s;
      tx_tdata   <= tdata_s;
      tx_tkeep   <= tkeep_s;
      tx_tstrb   <= tkeep_s;
      tx_tdest   <= tdest_s;
      tx_tuser   <= tuser_s;
      tx_tid     <= tid_s;
    end
  end

`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
  // Wrapping packet and byte counters, advanced on accepted beats.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stat_packets <= 32'd0;
      stat_bytes   <= 32'd0;
    end else if (hs_s) begin
      stat_packets <= stat_packets + (tx_tlast ? 32'd1 : 32'd0);
      stat_bytes   <= stat_bytes + popcount(MAX_BYTES'(tx_tkeep));
    end else begin
      stat_packets <= stat_packets;
      stat_bytes   <= stat_bytes;
    end
  end
`endif

endmodule

// File: tb/tb_logic_axi4_stream_packet_gen.sv
// Directed self-checking bench for logic_axi4_stream_packet_gen with TDATA_BYTES=4.
module tb_logic_axi4_stream_packet_gen;

  logic        aclk;
  logic        areset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_seed;
  logic [0:0]  cmd_tdest;
  logic [0:0]  cmd_tid;
  logic        tx_tvalid;
  logic        tx_tlast;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic [3:0]  tx_tstrb;
  logic [0:0]  tx_tdest;
  logic [0:0]  tx_tuser;
  logic [0:0]  tx_tid;
  logic        tx_tready;
  logic        busy;
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
  logic [31:0] stat_packets;
  logic [31:0] stat_bytes;
`endif

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  int hs_base  = 0;

  logic_axi4_stream_packet_gen #(
    .TDATA_BYTES  (4),
    .TDEST_WIDTH  (1),
    .TUSER_WIDTH  (1),
    .TID_WIDTH    (1),
    .LENGTH_WIDTH (16)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_length (cmd_length),
    .cmd_seed   (cmd_seed),
    .cmd_tdest  (cmd_tdest),
    .cmd_tid    (cmd_tid),
    .tx_tvalid  (tx_tvalid),
    .tx_tlast   (tx_tlast),
    .tx_tdata   (tx_tdata),
    .tx_tkeep   (tx_tkeep),
    .tx_tstrb   (tx_tstrb),
    .tx_tdest   (tx_tdest),
    .tx_tuser   (tx_tuser),
    .tx_tid     (tx_tid),
    .tx_tready  (tx_tready),
    .busy       (busy)
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
    ,
    .stat_packets (stat_packets),
    .stat_bytes   (stat_bytes)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (areset_n && tx_tvalid && tx_tready) hs_count <= hs_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset_n   = 1'b0;
    cmd_valid  = 1'b0;
    cmd_length = 16'd0;
    cmd_seed   = 8'h00;
    cmd_tdest  = 1'b0;
    cmd_tid    = 1'b0;
    tx_tready  = 1'b0;

    // reset state
    #2;
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tdata", 64'(tx_tdata), 64'd0);
    check("rst_tkeep", 64'(tx_tkeep), 64'd0);
    check("rst_tuser", 64'(tx_tuser), 64'd0);
    step();
    step();
    areset_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);

    // single full beat
    cmd_valid = 1'b1; cmd_length = 16'd4; cmd_seed = 8'h10;
    cmd_tdest = 1'b1; cmd_tid = 1'b1; tx_tready = 1'b1;
    hs_base = hs_count;
    step();
    cmd_valid = 1'b0;
    check("t1_tvalid", 64'(tx_tvalid), 64'd1);
    check("t1_tdata", 64'(tx_tdata), 64'h13121110);
    check("t1_tkeep", 64'(tx_tkeep), 64'hF);
    check("t1_tstrb", 64'(tx_tstrb), 64'hF);
    check("t1_tlast", 64'(tx_tlast), 64'd1);
    check("t1_tuser", 64'(tx_tuser), 64'd1);
    check("t1_tdest", 64'(tx_tdest), 64'd1);
    check("t1_tid", 64'(tx_tid), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_cmd_ready_last", 64'(cmd_ready), 64'd1);
    step();
    check("t1_idle_tvalid", 64'(tx_tvalid), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_beats", 64'(hs_count - hs_base), 64'd1);

    // seed wrap with partial final beat
    cmd_valid = 1'b1; cmd_length = 16'd6; cmd_seed = 8'hFE;
    cmd_tdest = 1'b0; cmd_tid = 1'b0;
    step();
    cmd_valid = 1'b0;
    check("t2_b1_tdata", 64'(tx_tdata), 64'h0100FFFE);
    check("t2_b1_tkeep", 64'(tx_tkeep), 64'hF);
    check("t2_b1_tlast", 64'(tx_tlast), 64'd0);
    check("t2_b1_tuser", 64'(tx_tuser), 64'd1);
    check("t2_b1_cmd_ready", 64'(cmd_ready), 64'd0);
    step();
    check("t2_b2_tdata", 64'(tx_tdata), 64'h00000302);
    check("t2_b2_tkeep", 64'(tx_tkeep), 64'h3);
    check("t2_b2_tstrb", 64'(tx_tstrb), 64'h3);
    check("t2_b2_tlast", 64'(tx_tlast), 64'd1);
    check("t2_b2_tuser", 64'(tx_tuser), 64'd0);
    step();
    check("t2_idle_tvalid", 64'(tx_tvalid), 64'd0);

    // backpressure on beat 2 of a 3-beat packet
    cmd_valid = 1'b1; cmd_length = 16'd12; cmd_seed = 8'h20;
    hs_base = hs_count;
    step();
    cmd_valid = 1'b0;
    check("t3_b1_tdata", 64'(tx_tdata), 64'h23222120);
    step();
    check("t3_b2_tdata", 64'(tx_tdata), 64'h27262524);
    tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall_tvalid", 64'(tx_tvalid), 64'd1);
      check("t3_stall_tdata", 64'(tx_tdata), 64'h27262524);
      check("t3_stall_tkeep", 64'(tx_tkeep), 64'hF);
      check("t3_stall_tlast", 64'(tx_tlast), 64'd0);
      check("t3_stall_tuser", 64'(tx_tuser), 64'd0);
    end
    tx_tready = 1'b1;
    step();
    check("t3_b3_tdata", 64'(tx_tdata), 64'h2B2A2928);
    check("t3_b3_tlast", 64'(tx_tlast), 64'd1);
    step();
    check("t3_idle_tvalid", 64'(tx_tvalid), 64'd0);
    check("t3_beats", 64'(hs_count - hs_base), 64'd3);

    // back-to-back packets
    cmd_valid = 1'b1; cmd_length = 16'd4; cmd_seed = 8'h40;
    hs_base = hs_count;
    step();
    check("t4_a_tdata", 64'(tx_tdata), 64'h43424140);
    check("t4_a_tlast", 64'(tx_tlast), 64'd1);
    check("t4_a_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_seed = 8'h50;
    step();
    cmd_valid = 1'b0;
    check("t4_b_tvalid", 64'(tx_tvalid), 64'd1);
    check("t4_b_tdata", 64'(tx_tdata), 64'h53525150);
    check("t4_b_tuser", 64'(tx_tuser), 64'd1);
    check("t4_hs_consecutive", 64'(hs_count - hs_base), 64'd1);
    step();
    check("t4_idle_tvalid", 64'(tx_tvalid), 64'd0);
    check("t4_beats", 64'(hs_count - hs_base), 64'd2);

`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
    check("stat_packets_pre", 64'(stat_packets), 64'd5);
    check("stat_bytes_pre", 64'(stat_bytes), 64'd30);
`endif

    // zero-length command is consumed silently
    cmd_valid = 1'b1; cmd_length = 16'd0; cmd_seed = 8'h99;
    check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    check("t5_tvalid", 64'(tx_tvalid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    step();
    check("t5_tvalid_later", 64'(tx_tvalid), 64'd0);
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
    check("stat_packets_len0", 64'(stat_packets), 64'd5);
`endif

    // reset mid-packet
    cmd_valid = 1'b1; cmd_length = 16'd12; cmd_seed = 8'h60; tx_tready = 1'b0;
    step();
    cmd_valid = 1'b0;
    check("t6_tdata", 64'(tx_tdata), 64'h63626160);
    check("t6_busy", 64'(busy), 64'd1);
    step();
    areset_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("t6_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_tdata", 64'(tx_tdata), 64'd0);
    step();
    areset_n = 1'b1;
    #1;
    check("t6_rel_busy", 64'(busy), 64'd0);
    check("t6_rel_tvalid", 64'(tx_tvalid), 64'd0);
    check("t6_rel_cmd_ready", 64'(cmd_ready), 64'd1);
`ifdef LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN
    check("stat_packets_rst", 64'(stat_packets), 64'd0);
`endif
    tx_tready = 1'b1;
    cmd_valid = 1'b1; cmd_length = 16'd4; cmd_seed = 8'h70;
    step();
    cmd_valid = 1'b0;
    check("t6_new_tdata", 64'(tx_tdata), 64'h73727170);
    check("t6_new_tuser", 64'(tx_tuser), 64'd1);
    check("t6_new_tlast", 64'(tx_tlast), 64'd1);
    step();
    check("t6_new_idle", 64'(tx_tvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_axi4_stream_packet_gen.md
LOGIC_AXI4_STREAM_PACKET_GEN -- requirements
Module: logic_axi4_stream_packet_gen

Interface
REQ-001 SHALL have parameter TDATA_BYTES, default 4: tdata width in bytes, minimum 1.
REQ-002 SHALL have parameter TDEST_WIDTH, default 1: tdest width.
REQ-003 SHALL have parameter TUSER_WIDTH, default 1: tuser width.
REQ-004 SHALL have parameter TID_WIDTH, default 1: tid width.
REQ-005 SHALL have parameter LENGTH_WIDTH, default 16: packet length field width, in bytes.
REQ-006 SHALL have port aclk, input, 1: the only clock; all logic rising-edge.
REQ-007 SHALL have port areset_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1: command valid.
REQ-009 SHALL have port cmd_ready, output, 1: command accepted when high with cmd_valid.
REQ-010 SHALL have port cmd_length, input, LENGTH_WIDTH: packet length in bytes.
REQ-011 SHALL have port cmd_seed, input, 8: value of the first payload byte.
REQ-012 SHALL have port cmd_tdest, input, TDEST_WIDTH: tdest for the whole packet.
REQ-013 SHALL have port cmd_tid, input, TID_WIDTH: tid for the whole packet.
REQ-014 SHALL have ports tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tstrb, tx_tdest, tx_tuser and tx_tid as outputs of width 1, 1, TDATA_BYTES x 8, TDATA_BYTES, TDATA_BYTES, TDEST_WIDTH, TUSER_WIDTH and TID_WIDTH: the AXI4-Stream transmitter.
REQ-015 SHALL have port tx_tready, input, 1: sink ready.
REQ-016 SHALL have port busy, output, 1: high while a packet is in flight.

Function
REQ-017 SHALL implement FSM states IDLE and SEND; IDLE->SEND on accepting a nonzero-length command; SEND->IDLE on the last-beat handshake with no new command accepted.
REQ-018 SHALL drive cmd_ready = (state==IDLE) OR (tx_tvalid AND tx_tready AND tx_tlast), giving back-to-back packets with no idle cycle.
REQ-019 SHALL accept a cmd_length of 0 and discard it: no beats sent, state unchanged.
REQ-020 SHALL present the first beat on the cycle after command acceptance, so latency is 1 cycle.
REQ-021 SHALL send ceil(cmd_length/TDATA_BYTES) beats, with payload byte i = (cmd_seed + i) mod 256 and byte 0 in tdata[7:0].
REQ-022 SHALL assert tx_tlast only on the final beat.
REQ-023 SHALL set tx_tkeep = tx_tstrb to all ones on non-final beats; on the final beat, only the low (cmd_length mod TDATA_BYTES) bits are set, or all ones when the remainder is 0.
REQ-024 SHALL drive data bytes with keep=0 to zero.
REQ-025 SHALL set tx_tuser[0] to 1 on the first beat only and hold all other tuser bits at 0.
REQ-026 SHALL hold tx_tdest and tx_tid constant for the whole packet.
REQ-027 SHALL keep all tx_* outputs registered and hold them stable while tx_tvalid=1 and tx_tready=0.
REQ-028 SHALL advance to the next beat only on tx_tvalid AND tx_tready.
REQ-029 SHALL use a beat counter of LENGTH_WIDTH bits and a seed that wraps modulo 256.
REQ-030 SHALL drive busy = (state==SEND).

Reset
REQ-031 SHALL, while areset_n=0, asynchronously force state to IDLE, tx_tvalid 0, tx_tlast 0, tx_tdata/tkeep/tstrb/tdest/tuser/tid to 0, busy 0 and counters to 0.
REQ-032 SHALL abort any in-flight packet on reset, with no resumption afterwards.
REQ-033 SHALL drive cmd_ready to 0 during reset and to 1 on the first cycle after deassertion.

Configuration
REQ-034 SHALL, with LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN defined, add output stat_packets (32 bits), incremented on each last-beat handshake, and output stat_bytes (32 bits), incremented by the popcount of tkeep on each handshake; both wrap and both reset to 0.
REQ-035 SHALL, without LOGIC_AXI4_STREAM_PACKET_GEN_STATS_EN, leave stat_packets and stat_bytes absent and instantiate no counter logic.

Structure
REQ-036 SHALL place the FSM state enum and the keep-mask/beat-count helper functions in package logic_axi4_stream_packet_gen_pkg.
REQ-037 SHALL have one sub-module, logic_axi4_stream_packet_gen_beat, a combinational formatter from (seed, beat index, remaining bytes) to tdata/tkeep/tlast.
REQ-038 SHALL have a top wrapper logic_axi4_stream_packet_gen_top exposing flat ports through logic_axi4_stream_if.

Verification (TDATA_BYTES=4)
REQ-039 SHALL cover: len=4, seed=0x10, tready=1 -> one beat, tdata=0x13121110, tkeep=0xF, tlast=1, tuser=1.
REQ-040 SHALL cover: len=6, seed=0xFE -> beat 1: 0x0100FFFE, keep 0xF, tlast=0; beat 2: 0x00000302, keep 0x3, tlast=1, tuser=0.
REQ-041 SHALL cover: len=12 with tready low for 5 cycles at beat 2 -> beat 2 outputs bit-stable, 3 beats total, no loss or duplication.
REQ-042 SHALL cover: two len=4 commands back-to-back with tready=1 -> handshakes on consecutive cycles and cmd_ready high on the tlast cycle.
REQ-043 SHALL cover: len=0 command -> cmd accepted, tx_tvalid stays 0, stat_packets unchanged.
REQ-044 SHALL cover: areset_n low mid-packet -> tx_tvalid 0 immediately, IDLE after release, next command starts a fresh packet with tuser=1.
